riscv_test_monitor: RTL and testbench
=====================================

# riscv_test_monitor

Synthesizable end-of-test monitor for the dual-issue `riscv_core`. It counts cycles and retired instructions across a configurable number of issue pipes. It detects the end-of-test CSR write, waits a drain interval, then reads back a configurable number of 32-bit result words over a request/response port and compares each against an expected vector. It sits beside `riscv_core`/`tcm_mem` on an FPGA or emulation build and replaces simulation-only checking with status outputs.

## Interface
- `PIPES`, 2, number of retirement strobes (issue pipes)
- `NUM_RESULTS`, 11, result words checked (≥1)
- `BASE_ADDR`, 32'h80000000, byte address of result word 0
- `DRAIN_CYCLES`, 10, cycles between end detect and first read (≥0)
- `TIMEOUT_CYCLES`, 100000, cycle count at which the run is declared timed out
- `CNT_W`, 32, width of cycle/instruction counters

- `clk_i` in 1: the single clock
- `rst_ni` in 1: reset, asynchronous assert, active-low
- `retire_i` in PIPES: one bit per pipe, instruction retired this cycle
- `end_i` in 1: end-of-test strobe (CSR write valid in exec0)
- `exp_data_i` in NUM_RESULTS*32: expected word k at bits [32k+31:32k]; static during check
- `rd_req_o` out 1: read request
- `rd_addr_o` out 32: byte address, BASE_ADDR + 4*k
- `rd_accept_i` in 1: request accepted
- `rd_valid_i` in 1: read data valid
- `rd_data_i` in 32: read data
- `cycle_count_o` out CNT_W: cycles counted
- `instr_count_o` out CNT_W: instructions retired
- `pass_count_o` out $clog2(NUM_RESULTS+1): matching words
- `fail_map_o` out NUM_RESULTS: bit k set when word k mismatched
- `busy_o` out 1: drain or read in progress
- `done_o` out 1: check or timeout finished (sticky)
- `pass_o` out 1: done, no timeout, pass_count == NUM_RESULTS
- `timeout_o` out 1: timed out (sticky)

## Operation
- FSM states: RUN, DRAIN, REQ, WAIT, DONE, TOUT. Reset enters RUN.
- RUN behaviour:
  - `cycle_count` increments every cycle.
  - `instr_count` adds popcount(`retire_i`) every cycle.
  - Both counters saturate at all-ones.
  - `end_i` goes to DRAIN. Counters still include the end cycle, then freeze.
  - Timeout: `cycle_count` == TIMEOUT_CYCLES-1 without `end_i` goes to TOUT. If `end_i` arrives in the same cycle, `end_i` wins.
- DRAIN: counts DRAIN_CYCLES cycles, then goes to REQ. With DRAIN_CYCLES=0 it passes straight to REQ.
- REQ: `rd_req_o`=1 with `rd_addr_o` = BASE_ADDR+4*idx. Holds until `rd_accept_i`, then goes to WAIT.
- WAIT: on `rd_valid_i`, compares `rd_data_i` with word idx.
  - Match: increments `pass_count`.
  - Mismatch: sets `fail_map[idx]`.
  - If idx == NUM_RESULTS-1, goes to DONE; otherwise idx++ and back to REQ.
- Only one read is outstanding at a time. `rd_valid_i` outside WAIT is ignored.
- `end_i` outside RUN is ignored.
- DONE and TOUT are terminal until reset.
- `busy_o` = DRAIN|REQ|WAIT.

## Timing
- Reset values: all counters 0, `fail_map_o` 0, `rd_req_o`/`busy_o`/`done_o`/`pass_o`/`timeout_o` 0, `rd_addr_o` = BASE_ADDR.
- All outputs are registered. `done_o`/`pass_o` assert the cycle after the final `rd_valid_i`.
- `rd_req_o` and `rd_addr_o` assert the cycle after DRAIN ends and stay stable while unaccepted.
- `rd_accept_i` and `rd_valid_i` may be high in the same cycle. Valid is honoured only in the cycle after accept or later.
- Minimum check latency from `end_i`: 1 + DRAIN_CYCLES + 2*NUM_RESULTS cycles (accept and valid each one cycle after the request).
- Reset asserted mid-check: immediate return to RUN with all state cleared. Any in-flight response after reset is ignored.

## Structure
- Package `riscv_test_monitor_pkg` holds:
  - the state enum;
  - the localparam for the pass-count width;
  - a popcount function for `retire_i`.
- One sub-module, `riscv_test_monitor_cnt`: a saturating counter with enable and increment input, used for both cycle and instruction counts.

## Test plan
- Basic pass:
  - Stimulus: PIPES=2, NUM_RESULTS=11, end after 500 cycles with both pipes retiring every cycle. A memory model returns the expected words with 1-cycle latency.
  - Required: `cycle_count_o`=500, `instr_count_o`=1000, `pass_count_o`=11, `pass_o`=1, `fail_map_o`=0.
- Single mismatch: word 6 returns 0xDEAD → `pass_count_o`=10, `fail_map_o`=11'h040, `pass_o`=0, `done_o`=1.
- Timeout: TIMEOUT_CYCLES=1000, `end_i` never asserted → `timeout_o`=1 and `done_o`=1 with `cycle_count_o`=1000, no `rd_req_o` ever issued.
- Backpressure:
  - Stimulus: `rd_accept_i` withheld 3 cycles per request, `rd_valid_i` 5 cycles after accept.
  - Required: `rd_addr_o` stable while waiting, addresses 0x80000000..0x80000028 in order, result as in the basic pass.
- Edge events:
  - `end_i` and timeout in the same cycle → check proceeds, `timeout_o`=0.
  - `end_i` re-pulsed during REQ → ignored.
  - DRAIN_CYCLES=0 → first `rd_req_o` one cycle after `end_i`.
- Reset mid-WAIT: a late `rd_valid_i` arriving after reset leaves all outputs at reset values and the FSM in RUN.

Source files
------------

// File: rtl/riscv_test_monitor_pkg.sv
// riscv_test_monitor_pkg
// Shared types and helpers for the end-of-test monitor:
//   - mon_state_e : monitor FSM state encoding
//   - MAX_PIPES   : widest retirement vector the popcount helper accepts
//   - POP_W       : width of a popcount result over MAX_PIPES bits
//   - pass_cnt_w  : width of the pass counter for a given number of results
//   - popcount    : number of set bits in a retirement vector
package riscv_test_monitor_pkg;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_DRAIN = 3'd1,
        ST_REQ   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_TOUT  = 3'd5
    } mon_state_e;

    localparam int unsigned MAX_PIPES = 32;
    localparam int unsigned POP_W     = 6;

    // Pass counter must be able to hold the value n itself.
    function automatic int unsigned pass_cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic logic [POP_W-1:0] popcount(input logic [MAX_PIPES-1:0] v);
        logic [POP_W-1:0] acc;
        acc = 6'd0;
        for (int i = 0; i < MAX_PIPES; i++) begin
            acc = acc + {5'd0, v[i]};
        end
        return acc;
    endfunction

endpackage

// File: rtl/riscv_test_monitor_cnt.sv
// riscv_test_monitor_cnt
// Saturating up-counter with enable and variable increment.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset, clears the count
//   en_i    : count enable; count holds when low
//   inc_i   : amount added per enabled cycle
//   count_o : registered count, sticks at all-ones once reached
module riscv_test_monitor_cnt #(
    parameter int unsigned W     = 32,
    parameter int unsigned INC_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [INC_W-1:0] inc_i,
    output logic [W-1:0]     count_o
);

    logic [W-1:0] count_r;
    logic [W-1:0] count_nxt_s;
    logic [W:0]   sum_s;

    // Next count: one extra sum bit detects overflow so the count clamps at all-ones.
    always_comb begin
        sum_s = {1'b0, count_r} + (W+1)'(inc_i);
        if (!en_i) begin
            count_nxt_s = count_r;
        end else if (sum_s[W]) begin
            count_nxt_s = {W{1'b1}};
        end else begin
            count_nxt_s = sum_s[W-1:0];
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_r <= {W{1'b0}};
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign count_o = count_r;

endmodule

// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor
// End-of-test monitor for riscv_core. Counts cycles and retired instructions
// until the end-of-test strobe, waits a drain interval, then reads NUM_RESULTS
// words starting at BASE_ADDR one at a time and compares them with exp_data_i.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   retire_i               : one retirement strobe per issue pipe
//   end_i                  : end-of-test strobe (only honoured while running)
//   exp_data_i             : expected word k at bits [32k+31:32k]
//   rd_req_o/rd_addr_o     : read request and byte address (held until accepted)
//   rd_accept_i            : request accepted
//   rd_valid_i/rd_data_i   : read response (honoured only while waiting for one)
//   cycle_count_o          : cycles counted while running (saturating)
//   instr_count_o          : retired instructions while running (saturating)
//   pass_count_o           : number of matching words
//   fail_map_o             : bit k set when word k mismatched
//   busy_o, done_o, pass_o, timeout_o : status flags, all registered
module riscv_test_monitor
    import riscv_test_monitor_pkg::*;
#(
    parameter int unsigned PIPES          = 2,
    parameter int unsigned NUM_RESULTS    = 11,
    parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
    parameter int unsigned DRAIN_CYCLES   = 10,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [PIPES-1:0]                   retire_i,
    input  logic                               end_i,
    input  logic [NUM_RESULTS*32-1:0]          exp_data_i,
    output logic                               rd_req_o,
    output logic [31:0]                        rd_addr_o,
    input  logic                               rd_accept_i,
    input  logic                               rd_valid_i,
    input  logic [31:0]                        rd_data_i,
    output logic [CNT_W-1:0]                   cycle_count_o,
    output logic [CNT_W-1:0]                   instr_count_o,
    output logic [$clog2(NUM_RESULTS+1)-1:0]   pass_count_o,
    output logic [NUM_RESULTS-1:0]             fail_map_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               pass_o,
    output logic                               timeout_o
);

    localparam int unsigned PASS_W = pass_cnt_w(NUM_RESULTS);
    localparam int unsigned IDX_W  = (NUM_RESULTS > 1) ? $clog2(NUM_RESULTS) : 1;
    localparam int unsigned DRN_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_RESULTS - 1);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] TOUT_AT    = CNT_W'(TIMEOUT_CYCLES - 1);

    mon_state_e            state_r, state_nxt_s;
    logic [DRN_W-1:0]      drain_cnt_r, drain_cnt_nxt_s;
    logic [IDX_W-1:0]      idx_r, idx_nxt_s;
    logic [PASS_W-1:0]     pass_cnt_r, pass_cnt_nxt_s;
    logic [NUM_RESULTS-1:0] fail_map_r, fail_map_nxt_s;

    logic                  rd_req_r, rd_req_nxt_s;
    logic [31:0]           rd_addr_r, rd_addr_nxt_s;
    logic                  busy_r, busy_nxt_s;
    logic                  done_r, done_nxt_s;
    logic                  pass_r, pass_nxt_s;
    logic                  timeout_r, timeout_nxt_s;

    logic                  run_s;
    logic                  hit_s;
    logic [31:0]           exp_word_s;
    logic [MAX_PIPES-1:0]  retire_ext_s;
    logic [CNT_W-1:0]      cycle_cnt_s;
    logic [CNT_W-1:0]      instr_cnt_s;

    assign run_s        = (state_r == ST_RUN);
    assign retire_ext_s = MAX_PIPES'(retire_i);
    assign exp_word_s   = exp_data_i[32*idx_r +: 32];
    // A response only counts once the request has been accepted.
    assign hit_s        = rd_valid_i && (state_r == ST_WAIT);

    riscv_test_monitor_cnt #(.W(CNT_W), .INC_W(1)) u_cycle_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (run_s),
        .inc_i   (1'b1),
        .count_o (cycle_cnt_s)
    );

    riscv_test_monitor_cnt #(.W(CNT_W), .INC_W(POP_W)) u_instr_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (run_s),
        .inc_i   (popcount(retire_ext_s)),
        .count_o (instr_cnt_s)
    );

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; end_i beats the timeout when both occur together.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (end_i) begin
                    if (DRAIN_CYCLES == 32'd0) begin
                        state_nxt_s = ST_REQ;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end else if (cycle_cnt_s == TOUT_AT) begin
                    state_nxt_s = ST_TOUT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_REQ: begin
                if (rd_accept_i) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (!rd_valid_i) begin
                    state_nxt_s = ST_WAIT;
                end else if (idx_r == LAST_IDX) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_DONE: state_nxt_s = ST_DONE;
            ST_TOUT: state_nxt_s = ST_TOUT;
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // Datapath next values: drain timer, word index and compare results.
    always_comb begin
        drain_cnt_nxt_s = {DRN_W{1'b0}};
        idx_nxt_s       = idx_r;
        pass_cnt_nxt_s  = pass_cnt_r;
        fail_map_nxt_s  = fail_map_r;
        if (state_r == ST_DRAIN) begin
            drain_cnt_nxt_s = drain_cnt_r + {{(DRN_W-1){1'b0}}, 1'b1};
        end else begin
            drain_cnt_nxt_s = {DRN_W{1'b0}};
        end
        if (hit_s) begin
            if (rd_data_i == exp_word_s) begin
                pass_cnt_nxt_s = pass_cnt_r + {{(PASS_W-1){1'b0}}, 1'b1};
            end else begin
                fail_map_nxt_s[idx_r] = 1'b1;
            end
            if (idx_r != LAST_IDX) begin
                idx_nxt_s = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end else begin
                idx_nxt_s = idx_r;
            end
        end else begin
            idx_nxt_s = idx_r;
        end
    end

    // Output values for the next cycle, derived from the next state so that the
    // registered flags line up with the state they describe.
    always_comb begin
        rd_req_nxt_s  = (state_nxt_s == ST_REQ);
        rd_addr_nxt_s = BASE_ADDR + 32'({idx_nxt_s, 2'b00});
        busy_nxt_s    = (state_nxt_s == ST_DRAIN) || (state_nxt_s == ST_REQ) ||
                        (state_nxt_s == ST_WAIT);
        done_nxt_s    = (state_nxt_s == ST_DONE) || (state_nxt_s == ST_TOUT);
        timeout_nxt_s = (state_nxt_s == ST_TOUT);
        pass_nxt_s    = (state_nxt_s == ST_DONE) && (pass_cnt_nxt_s == PASS_W'(NUM_RESULTS));
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drain_cnt_r <= {DRN_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            pass_cnt_r  <= {PASS_W{1'b0}};
            fail_map_r  <= {NUM_RESULTS{1'b0}};
            rd_req_r    <= 1'b0;
            rd_addr_r   <= BASE_ADDR;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            drain_cnt_r <= drain_cnt_nxt_s;
            idx_r       <= idx_nxt_s;
            pass_cnt_r  <= pass_cnt_nxt_s;
            fail_map_r  <= fail_map_nxt_s;
            rd_req_r    <= rd_req_nxt_s;
            rd_addr_r   <= rd_addr_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            pass_r      <= pass_nxt_s;
            timeout_r   <= timeout_nxt_s;
        end
    end

    assign rd_req_o      = rd_req_r;
    assign rd_addr_o     = rd_addr_r;
    assign cycle_count_o = cycle_cnt_s;
    assign instr_count_o = instr_cnt_s;
    assign pass_count_o  = pass_cnt_r;
    assign fail_map_o    = fail_map_r;
    assign busy_o        = busy_r;
    assign done_o        = done_r;
    assign pass_o        = pass_r;
    assign timeout_o     = timeout_r;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Testbench for riscv_test_monitor. Main instance: 11 results, drain 10,
// timeout 1000. Second instance: drain 0, never accepted, used for the
// request-timing edge case. Expected values come from a small model in the
// bench: counts from the number of run cycles and retired bits, results
// from which words are returned corrupted, latency from the handshake delays.
module tb_riscv_test_monitor;

    localparam int          NR   = 11;
    localparam int          DR   = 10;
    localparam int          TO   = 1000;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          PW   = $clog2(NR + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        retire;
    logic              end_s, end0_s;
    logic [NR*32-1:0]  exp_data;
    logic              rd_accept, rd_valid, accept0;
    logic [31:0]       rd_data;

    logic              rd_req, busy, done, pass, tout;
    logic [31:0]       rd_addr, cyc_cnt, ins_cnt;
    logic [PW-1:0]     pass_cnt;
    logic [NR-1:0]     fail_map;

    logic              rd_req0, busy0, done0, pass0, tout0;
    logic [31:0]       rd_addr0, cyc_cnt0, ins_cnt0;
    logic [PW-1:0]     pass_cnt0;
    logic [NR-1:0]     fail_map0;

    int                n_chk = 0;
    int                n_fail = 0;
    int                cyc = 0;
    logic [31:0]       exp_w [NR];

    riscv_test_monitor #(.PIPES(2), .NUM_RESULTS(NR), .BASE_ADDR(BASE),
        .DRAIN_CYCLES(DR), .TIMEOUT_CYCLES(TO), .CNT_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .retire_i(retire), .end_i(end_s),
        .exp_data_i(exp_data), .rd_req_o(rd_req), .rd_addr_o(rd_addr),
        .rd_accept_i(rd_accept), .rd_valid_i(rd_valid), .rd_data_i(rd_data),
        .cycle_count_o(cyc_cnt), .instr_count_o(ins_cnt), .pass_count_o(pass_cnt),
        .fail_map_o(fail_map), .busy_o(busy), .done_o(done), .pass_o(pass),
        .timeout_o(tout));

    riscv_test_monitor #(.PIPES(2), .NUM_RESULTS(NR), .BASE_ADDR(BASE),
        .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(TO), .CNT_W(32)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .retire_i(retire), .end_i(end0_s),
        .exp_data_i(exp_data), .rd_req_o(rd_req0), .rd_addr_o(rd_addr0),
        .rd_accept_i(accept0), .rd_valid_i(rd_valid), .rd_data_i(rd_data),
        .cycle_count_o(cyc_cnt0), .instr_count_o(ins_cnt0), .pass_count_o(pass_cnt0),
        .fail_map_o(fail_map0), .busy_o(busy0), .done_o(done0), .pass_o(pass0),
        .timeout_o(tout0));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic load_words(input bit rnd);
        for (int k = 0; k < NR; k++) begin
            exp_w[k] = rnd ? 32'($urandom) : (32'h1000_0000 + 32'(k));
            exp_data[k*32 +: 32] = exp_w[k];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; end_s = 1'b0; end0_s = 1'b0; retire = 2'b00;
        rd_accept = 1'b0; rd_valid = 1'b0; rd_data = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs len cycles with end_i on the last one; returns the end cycle and
    // the number of instructions retired (sum of set retire bits).
    task automatic run_phase(input int len, input bit rnd, output int e_cyc, output int instr);
        instr = 0;
        e_cyc = 0;
        for (int i = 0; i < len; i++) begin
            retire = rnd ? 2'($urandom) : 2'b11;
            instr += int'(retire[0]) + int'(retire[1]);
            end_s = (i == len - 1);
            if (i == len - 1) e_cyc = cyc;
            @(negedge clk);
        end
        end_s = 1'b0;
        retire = 2'b00;
    endtask

    // Memory responder: stalls acc_dly cycles before accepting, answers val_dly
    // cycles after the accept cycle. Optionally drives junk responses while no
    // response is due, and re-pulses end_i while word repulse_k is pending.
    task automatic serve(input int acc_dly, input int val_dly, input logic [NR-1:0] bad,
                         input bit junk, input int repulse_k);
        for (int k = 0; k < NR; k++) begin
            int w;
            logic [31:0] a0;
            bit stable;
            w = 0;
            while (rd_req !== 1'b1 && w < 200) begin
                @(negedge clk);
                w++;
            end
            n_chk++;
            if (rd_req !== 1'b1) begin
                n_fail++;
                $display("FAIL serve_req word %0d: rd_req_o=%b, required 1 within 200 cycles", k, rd_req);
                return;
            end
            n_chk++;
            if (rd_addr !== BASE + 32'(4*k)) begin
                n_fail++;
                $display("FAIL rd_addr word %0d: got %h, required %h", k, rd_addr, BASE + 32'(4*k));
            end
            a0 = rd_addr;
            stable = 1'b1;
            for (int s = 0; s < acc_dly; s++) begin
                rd_valid = junk;
                rd_data = ~exp_w[k];
                end_s = (k == repulse_k) && (s == 0);
                @(negedge clk);
                if (rd_req !== 1'b1 || rd_addr !== a0) stable = 1'b0;
            end
            end_s = 1'b0;
            rd_accept = 1'b1;
            rd_valid = junk;
            rd_data = ~exp_w[k];
            @(negedge clk);
            rd_accept = 1'b0;
            rd_valid = 1'b0;
            if (acc_dly > 0) begin
                n_chk++;
                if (!stable) begin
                    n_fail++;
                    $display("FAIL addr_stable word %0d: rd_req_o/rd_addr_o changed before accept, required stable at %h", k, a0);
                end
            end
            for (int s = 1; s < val_dly; s++) @(negedge clk);
            rd_valid = 1'b1;
            rd_data = bad[k] ? ((exp_w[k] == 32'hDEAD) ? 32'hBEEF : 32'hDEAD) : exp_w[k];
            @(negedge clk);
            rd_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        retire = 2'b11;
        repeat (5) @(negedge clk);
        do_reset();
        n_chk++;
        if (cyc_cnt !== 32'd0 || ins_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counts: cycle=%0d instr=%0d, required 0/0", cyc_cnt, ins_cnt);
        end
        n_chk++;
        if (pass_cnt !== PW'(0) || fail_map !== NR'(0) || rd_addr !== BASE) begin
            n_fail++;
            $display("FAIL reset_data: pass_count=%0d fail_map=%h addr=%h, required 0/0/%h", pass_cnt, fail_map, rd_addr, BASE);
        end
        n_chk++;
        if ({rd_req, busy, done, pass, tout} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_flags: req,busy,done,pass,tout=%b, required 00000", {rd_req, busy, done, pass, tout});
        end
    endtask

    task automatic test_basic_pass();
        int e, ins, w, t_req, t_done;
        load_words(1'b0);
        do_reset();
        run_phase(500, 1'b0, e, ins);
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy_drain: busy_o=%b, required 1", busy);
        end
        w = 0;
        while (rd_req !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        t_req = cyc - e;
        n_chk++;
        if (t_req !== 1 + DR) begin
            n_fail++;
            $display("FAIL basic_first_req: at %0d cycles after end, required %0d", t_req, 1 + DR);
        end
        serve(0, 1, NR'(0), 1'b0, -1);
        w = 0;
        while (done !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        t_done = cyc - e;
        n_chk++;
        if (t_done !== 1 + DR + 2*NR) begin
            n_fail++;
            $display("FAIL basic_latency: done after %0d cycles, required %0d", t_done, 1 + DR + 2*NR);
        end
        n_chk++;
        if (cyc_cnt !== 32'd500 || ins_cnt !== 32'(ins)) begin
            n_fail++;
            $display("FAIL basic_counts: cycle=%0d instr=%0d, required 500/%0d", cyc_cnt, ins_cnt, ins);
        end
        n_chk++;
        if (pass_cnt !== PW'(NR) || fail_map !== NR'(0) || {done, pass, tout, busy} !== 4'b1100) begin
            n_fail++;
            $display("FAIL basic_result: pass_count=%0d fail_map=%h done,pass,tout,busy=%b, required %0d/0/1100",
                     pass_cnt, fail_map, {done, pass, tout, busy}, NR);
        end
    endtask

    task automatic test_mismatch();
        int e, ins, w;
        load_words(1'b0);
        do_reset();
        run_phase(200, 1'b1, e, ins);
        serve(0, 1, 11'h040, 1'b0, -1);
        w = 0;
        while (done !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        n_chk++;
        if (pass_cnt !== PW'(10) || fail_map !== 11'h040) begin
            n_fail++;
            $display("FAIL mismatch_result: pass_count=%0d fail_map=%h, required 10/040", pass_cnt, fail_map);
        end
        n_chk++;
        if ({done, pass, tout} !== 3'b100 || cyc_cnt !== 32'd200 || ins_cnt !== 32'(ins)) begin
            n_fail++;
            $display("FAIL mismatch_flags: done,pass,tout=%b cycle=%0d instr=%0d, required 100/200/%0d",
                     {done, pass, tout}, cyc_cnt, ins_cnt, ins);
        end
    endtask

    task automatic test_timeout();
        int base, t_done;
        bit saw_req;
        do_reset();
        base = cyc;
        saw_req = 1'b0;
        t_done = -1;
        retire = 2'b01;
        for (int i = 0; i < 1100 && t_done < 0; i++) begin
            @(negedge clk);
            if (rd_req === 1'b1) saw_req = 1'b1;
            if (done === 1'b1) t_done = cyc - base;
        end
        n_chk++;
        if (t_done !== TO) begin
            n_fail++;
            $display("FAIL timeout_time: done after %0d cycles, required %0d", t_done, TO);
        end
        // A late end_i must not revive a timed-out run.
        end_s = 1'b1;
        @(negedge clk);
        end_s = 1'b0;
        repeat (3) @(negedge clk);
        retire = 2'b00;
        n_chk++;
        if ({tout, done, pass, busy, saw_req} !== 5'b11000 || cyc_cnt !== 32'(TO) || ins_cnt !== 32'(TO)) begin
            n_fail++;
            $display("FAIL timeout_state: tout,done,pass,busy,saw_req=%b cycle=%0d instr=%0d, required 11000/%0d/%0d",
                     {tout, done, pass, busy, saw_req}, cyc_cnt, ins_cnt, TO, TO);
        end
    endtask

    task automatic test_backpressure();
        int e, ins, w, t_done;
        load_words(1'b1);
        do_reset();
        run_phase(500, 1'b0, e, ins);
        serve(3, 5, NR'(0), 1'b1, 3);
        w = 0;
        while (done !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        t_done = cyc - e;
        n_chk++;
        if (t_done !== 1 + DR + NR*(3 + 5 + 1)) begin
            n_fail++;
            $display("FAIL bp_latency: done after %0d cycles, required %0d", t_done, 1 + DR + NR*9);
        end
        n_chk++;
        if (pass_cnt !== PW'(NR) || fail_map !== NR'(0) || {done, pass, tout} !== 3'b110 ||
            cyc_cnt !== 32'd500 || ins_cnt !== 32'd1000) begin
            n_fail++;
            $display("FAIL bp_result: pass_count=%0d fail_map=%h done,pass,tout=%b cycle=%0d instr=%0d, required %0d/0/110/500/1000",
                     pass_cnt, fail_map, {done, pass, tout}, cyc_cnt, ins_cnt, NR);
        end
    endtask

    task automatic test_end_at_timeout();
        int e, ins, w;
        load_words(1'b1);
        do_reset();
        run_phase(TO, 1'b1, e, ins);
        serve(0, 1, NR'(0), 1'b0, -1);
        w = 0;
        while (done !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        n_chk++;
        if ({done, pass, tout} !== 3'b110 || cyc_cnt !== 32'(TO) || ins_cnt !== 32'(ins)) begin
            n_fail++;
            $display("FAIL end_at_timeout: done,pass,tout=%b cycle=%0d instr=%0d, required 110/%0d/%0d",
                     {done, pass, tout}, cyc_cnt, ins_cnt, TO, ins);
        end
    endtask

    task automatic test_drain_zero();
        do_reset();
        repeat (20) @(negedge clk);
        end0_s = 1'b1;
        n_chk++;
        if (rd_req0 !== 1'b0) begin
            n_fail++;
            $display("FAIL dz_req_early: rd_req_o=%b at end cycle, required 0", rd_req0);
        end
        @(negedge clk);
        end0_s = 1'b0;
        n_chk++;
        if (rd_req0 !== 1'b1 || rd_addr0 !== BASE || busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL dz_first_req: req=%b addr=%h busy=%b, required 1/%h/1", rd_req0, rd_addr0, busy0, BASE);
        end
        repeat (3) @(negedge clk);
        n_chk++;
        if (rd_req0 !== 1'b1 || rd_addr0 !== BASE || cyc_cnt0 !== 32'd21) begin
            n_fail++;
            $display("FAIL dz_hold: req=%b addr=%h cycle=%0d, required 1/%h/21", rd_req0, rd_addr0, cyc_cnt0, BASE);
        end
    endtask

    task automatic test_reset_mid_wait();
        int e, ins, w;
        load_words(1'b0);
        do_reset();
        run_phase(30, 1'b1, e, ins);
        w = 0;
        while (rd_req !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        rd_accept = 1'b1;
        @(negedge clk);
        rd_accept = 1'b0;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({rd_req, busy, done, pass, tout} !== 5'b00000 || cyc_cnt !== 32'd0 || rd_addr !== BASE) begin
            n_fail++;
            $display("FAIL rst_async: req,busy,done,pass,tout=%b cycle=%0d addr=%h, required 00000/0/%h",
                     {rd_req, busy, done, pass, tout}, cyc_cnt, rd_addr, BASE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rd_valid = 1'b1;
        rd_data = exp_w[0];
        @(negedge clk);
        rd_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({rd_req, busy, done, pass, tout} !== 5'b00000 || pass_cnt !== PW'(0) || fail_map !== NR'(0) ||
            rd_addr !== BASE || cyc_cnt !== 32'd2 || ins_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_late_valid: flags=%b pass_count=%0d fail_map=%h addr=%h cycle=%0d instr=%0d, required 00000/0/0/%h/2/0",
                     {rd_req, busy, done, pass, tout}, pass_cnt, fail_map, rd_addr, cyc_cnt, ins_cnt, BASE);
        end
        run_phase(40, 1'b0, e, ins);
        serve(0, 1, NR'(0), 1'b0, -1);
        w = 0;
        while (done !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        n_chk++;
        if ({done, pass} !== 2'b11 || cyc_cnt !== 32'd42 || ins_cnt !== 32'd80) begin
            n_fail++;
            $display("FAIL rst_rerun: done,pass=%b cycle=%0d instr=%0d, required 11/42/80", {done, pass}, cyc_cnt, ins_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) begin
            int e, ins, w, len, acc, vd, t_done, nbad;
            logic [NR-1:0] bad;
            bit junk;
            len  = int'($urandom_range(20, 300));
            acc  = int'($urandom_range(0, 3));
            vd   = int'($urandom_range(1, 4));
            junk = 1'($urandom);
            bad  = NR'($urandom) & NR'($urandom);
            nbad = $countones(bad);
            load_words(1'b1);
            do_reset();
            run_phase(len, 1'b1, e, ins);
            serve(acc, vd, bad, junk, -1);
            w = 0;
            while (done !== 1'b1 && w < 100) begin @(negedge clk); w++; end
            t_done = cyc - e;
            n_chk++;
            if (t_done !== 1 + DR + NR*(acc + vd + 1)) begin
                n_fail++;
                $display("FAIL b2b_latency run %0d: done after %0d cycles, required %0d", r, t_done, 1 + DR + NR*(acc + vd + 1));
            end
            n_chk++;
            if (cyc_cnt !== 32'(len) || ins_cnt !== 32'(ins)) begin
                n_fail++;
                $display("FAIL b2b_counts run %0d: cycle=%0d instr=%0d, required %0d/%0d", r, cyc_cnt, ins_cnt, len, ins);
            end
            n_chk++;
            if (pass_cnt !== PW'(NR - nbad) || fail_map !== bad || pass !== (nbad == 0) || {done, tout} !== 2'b10) begin
                n_fail++;
                $display("FAIL b2b_result run %0d: pass_count=%0d fail_map=%h pass=%b done,tout=%b, required %0d/%h/%b/10",
                         r, pass_cnt, fail_map, pass, {done, tout}, NR - nbad, bad, (nbad == 0));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; end_s = 1'b0; end0_s = 1'b0; retire = 2'b00; accept0 = 1'b0;
        rd_accept = 1'b0; rd_valid = 1'b0; rd_data = 32'd0; exp_data = '0;
        test_reset();
        test_basic_pass();
        test_mismatch();
        test_timeout();
        test_backpressure();
        test_end_at_timeout();
        test_drain_zero();
        test_reset_mid_wait();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
